mundo_scroll: RTL

- Downstream consumer of the combinational pattern decoder's `Set` match flag.
- On a rising edge of the match, plays a short scrolling message across four multiplexed active-low 7-segment digits, holds the final frame, then returns to idle.
- Operation bit (`Op`) captured at trigger selects one of two messages.
- Sits between the decoder and the board's display pins.

---
 rtl/mundo_scroll.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mundo_scroll.sv
// mundo_scroll: on a set_in rising edge, scrolls "  HOLA  " or "  SUMA  " across four muxed 7-seg digits.
// Optional macro MUNDO_RETRIGGER_EN lets a new set_in edge restart a run that is already playing.
//
// state  | meaning
// IDLE   | display blanked, waiting for a set_in rising edge
// SCROLL | window advances one character per step, pos 0..4
// HOLD   | final frame (pos 4) held for HOLD_TICKS steps, then done
module mundo_scroll #(
  parameter int TICK_DIV   = 25000000,
  parameter int MUX_DIV    = 50000,
  parameter int HOLD_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_in,
  input  logic       op,
  output logic [6:0] seg_out,
  output logic [3:0] an_out,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  state_t        state, state_n;
  logic [2:0]    pos, pos_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          msel, msel_n;
  logic          set_d, rise, step, done_n;
  logic [MW-1:0] mux_cnt;
  logic [1:0]    dsel;
  logic [2:0]    idx;
  logic [6:0]    seg_n;
  logic [3:0]    an_n;

  // Message ROM; only indices 2..5 differ from blank.
  function automatic logic [6:0] glyph(input logic m, input logic [2:0] i);
    case (i)
      3'd2:    glyph = m ? 7'h12 : 7'h09;
      3'd3:    glyph = m ? 7'h41 : 7'h40;
      3'd4:    glyph = m ? 7'h48 : 7'h47;
      3'd5:    glyph = 7'h08;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    pos_n   = pos;
    tick_n  = tick_cnt;
    hold_n  = hold_cnt;
    msel_n  = msel;
    done_n  = 1'b0;
    rise    = set_in & ~set_d;
    step    = (tick_cnt == TICK_LAST);
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = SCROLL;
          pos_n   = 3'd0;
          tick_n  = '0;
          msel_n  = op;
        end
      end
      SCROLL, HOLD: begin
        tick_n = step ? '0 : tick_cnt + 1'b1;
        if (step) begin
          if (state == SCROLL) begin
            if (pos == 3'd4) begin
              state_n = HOLD;
              hold_n  = '0;
            end else begin
              pos_n = pos + 3'd1;
            end
          end else if (hold_cnt == HOLD_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            hold_n = hold_cnt + 1'b1;
          end
        end
`ifdef MUNDO_RETRIGGER_EN
        if (rise) begin
          state_n = SCROLL;
          pos_n   = 3'd0;
          tick_n  = '0;
          hold_n  = '0;
          msel_n  = op;
          done_n  = 1'b0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Display is built from next-state values so the first frame appears together with busy.
  always_comb begin
    idx   = pos_n + 3'd3 - {1'b0, dsel};
    seg_n = 7'h7F;
    an_n  = 4'hF;
    if (state_n != IDLE) begin
      seg_n = glyph(msel_n, idx);
      an_n  = ~(4'b0001 << dsel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= 3'd0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      msel     <= 1'b0;
      set_d    <= 1'b0;
      mux_cnt  <= '0;
      dsel     <= 2'd0;
      seg_out  <= 7'h7F;
      an_out   <= 4'hF;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      tick_cnt <= tick_n;
      hold_cnt <= hold_n;
      msel     <= msel_n;
      set_d    <= set_in;
      seg_out  <= seg_n;
      an_out   <= an_n;
      done     <= done_n;
      if (mux_cnt == MUX_LAST) begin
        mux_cnt <= '0;
        dsel    <= dsel + 2'd1;
      end else begin
        mux_cnt <= mux_cnt + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
